// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of a five-stage MIPS pipeline. It sits between the
// EX/MEM and MEM/WB pipeline registers. Each accepted instruction produces
// exactly one write-back result:
//   - a pass-through ALU result,
//   - a word or byte load/store over a req/ack data-memory bus, or
//   - a multi-cycle multiply (low 32 bits of the product).
// While an instruction is in flight, or while MEM/WB refuses a finished
// result, the stage back-pressures EX/MEM by dropping allow_out.
//
// Ports
//   clk, rsta            clock, synchronous active-high reset
//   valid_in/allow_out   EX/MEM handshake (allow_out is combinational)
//   ALU_result_in        address, pass-through value or multiplicand
//   w_in, reg_wen_in     destination register and its write enable
//   data_mem_en_in       memory access; data_mem_wen_in selects store
//   MEM_wdat_in          store data or multiplier
//   mul_en_in            multiply instruction
//   byte_en_in           byte-sized access (lb/sb)
//   allow_in/valid_out   MEM/WB handshake
//   wb_dat_out, w_out,
//   reg_wen_out          result presented to MEM/WB
//   dm_req/dm_we/dm_addr/
//   dm_wdat/dm_be        data-memory request, held stable while waiting
//   dm_ack/dm_rdat       data-memory completion, read data in same cycle
//
// Parameter
//   MUL_CYCLES           cycles from multiply acceptance to result (1..15)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rsta,
  // EX/MEM side
  input  logic        valid_in,
  output logic        allow_out,
  input  logic [31:0] ALU_result_in,
  input  logic [4:0]  w_in,
  input  logic        data_mem_en_in,
  input  logic        data_mem_wen_in,
  input  logic        reg_wen_in,
  input  logic [31:0] MEM_wdat_in,
  input  logic        mul_en_in,
  input  logic        byte_en_in,
  // MEM/WB side
  input  logic        allow_in,
  output logic        valid_out,
  output logic [31:0] wb_dat_out,
  output logic [4:0]  w_out,
  output logic        reg_wen_out,
  // Data-memory bus
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdat,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State and holding registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;     // ALU result of the in-flight instruction
  logic [31:0] data_q,  data_d;     // store data / multiplier
  logic [4:0]  w_q,     w_d;        // destination of the in-flight instruction
  logic        rwen_q,  rwen_d;
  logic        we_q,    we_d;
  logic        byte_q,  byte_d;
  logic [3:0]  cnt_q,   cnt_d;      // multiply cycles still to run
  // Presented result; only updated when a result is produced so that
  // wb_dat_out/w_out keep their last value while the next instruction runs.
  logic [31:0] res_q,   res_d;
  logic [4:0]  wout_q,  wout_d;
  logic        rwout_q, rwout_d;

  logic        accept;
  logic [31:0] mul_a, mul_b, mul_prod;
  logic [7:0]  load_byte;
  logic [31:0] load_val;

  // ---------------------------------------------------------------------------
  // Multiplier: with a single-cycle multiply the product is taken straight from
  // the EX/MEM fields at acceptance, otherwise from the held operands.
  // ---------------------------------------------------------------------------
  assign mul_a    = (MUL_CYCLES == 1) ? ALU_result_in : addr_q;
  assign mul_b    = (MUL_CYCLES == 1) ? MEM_wdat_in   : data_q;
  assign mul_prod = mul_a * mul_b;

  // Load data: byte lane addr[1:0], little-endian, sign-extended.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a value on all paths
    // (here via the default arm) so no latch is inferred.
    unique case (addr_q[1:0])
      2'd0:    load_byte = dm_rdat[7:0];
      2'd1:    load_byte = dm_rdat[15:8];
      2'd2:    load_byte = dm_rdat[23:16];
      default: load_byte = dm_rdat[31:24];
    endcase
  end

  assign load_val = byte_q ? {{24{load_byte[7]}}, load_byte} : dm_rdat;

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rsta) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      w_q     <= '0;
      rwen_q  <= 1'b0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      wout_q  <= '0;
      rwout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      w_q     <= w_d;
      rwen_q  <= rwen_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wout_q  <= wout_d;
      rwout_q <= rwout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next state and holding-register updates
  // ---------------------------------------------------------------------------
  assign accept = valid_in & allow_out;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    w_d     = w_q;
    rwen_d  = rwen_q;
    we_d    = we_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wout_d  = wout_q;
    rwout_d = rwout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          addr_d = ALU_result_in;
          data_d = MEM_wdat_in;
          w_d    = w_in;
          rwen_d = reg_wen_in;
          we_d   = data_mem_wen_in;
          byte_d = byte_en_in;
          // Memory access takes priority over multiply.
          if (data_mem_en_in) begin
            state_d = S_MEM;
          end else if (mul_en_in) begin
            if (MUL_CYCLES == 1) begin
              state_d = S_DONE;
              res_d   = mul_prod;
              wout_d  = w_in;
              rwout_d = reg_wen_in;
            end else begin
              state_d = S_MUL;
              cnt_d   = 4'(MUL_CYCLES - 1);
            end
          end else begin
            state_d = S_DONE;
            res_d   = ALU_result_in;
            wout_d  = w_in;
            rwout_d = reg_wen_in;
          end
        end else if (state_q == S_DONE && allow_in) begin
          state_d = S_IDLE;
        end
      end

      S_MEM: begin
        if (dm_ack) begin
          state_d = S_DONE;
          res_d   = we_q ? addr_q : load_val;
          wout_d  = w_q;
          rwout_d = rwen_q;
        end
      end

      S_MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = S_DONE;
          res_d   = mul_prod;
          wout_d  = w_q;
          rwout_d = rwen_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: outputs. Everything except allow_out is a function of
  // registers only; dm_ack/dm_rdat never reach an output combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    allow_out   = (state_q == S_IDLE) || ((state_q == S_DONE) && allow_in);
    valid_out   = (state_q == S_DONE);
    reg_wen_out = (state_q == S_DONE) && rwout_q;
    wb_dat_out  = res_q;
    w_out       = wout_q;

    dm_req  = 1'b0;
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_wdat = '0;
    dm_be   = '0;
    if (state_q == S_MEM) begin
      dm_req  = 1'b1;
      dm_we   = we_q;
      dm_addr = {addr_q[31:2], 2'b00};
      if (byte_q) begin
        dm_be   = 4'b0001 << addr_q[1:0];
        dm_wdat = {4{data_q[7:0]}};
      end else begin
        dm_be   = 4'b1111;
        dm_wdat = data_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int unsigned MUL_C = 2;

  logic        clk = 1'b0;
  logic        rsta;
  logic        valid_in;
  logic        allow_out;
  logic [31:0] ALU_result_in;
  logic [4:0]  w_in;
  logic        data_mem_en_in;
  logic        data_mem_wen_in;
  logic        reg_wen_in;
  logic [31:0] MEM_wdat_in;
  logic        mul_en_in;
  logic        byte_en_in;
  logic        allow_in;
  logic        valid_out;
  logic [31:0] wb_dat_out;
  logic [4:0]  w_out;
  logic        reg_wen_out;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdat;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdat;
    logic [4:0]  w;
    logic        reg_wen;
    logic        mem;
    logic        wr;
    logic        mul;
    logic        byt;
  } op_t;

  mem_stage #(.MUL_CYCLES(MUL_C)) dut (
    .clk            (clk),
    .rsta           (rsta),
    .valid_in       (valid_in),
    .allow_out      (allow_out),
    .ALU_result_in  (ALU_result_in),
    .w_in           (w_in),
    .data_mem_en_in (data_mem_en_in),
    .data_mem_wen_in(data_mem_wen_in),
    .reg_wen_in     (reg_wen_in),
    .MEM_wdat_in    (MEM_wdat_in),
    .mul_en_in      (mul_en_in),
    .byte_en_in     (byte_en_in),
    .allow_in       (allow_in),
    .valid_out      (valid_out),
    .wb_dat_out     (wb_dat_out),
    .w_out          (w_out),
    .reg_wen_out    (reg_wen_out),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdat        (dm_wdat),
    .dm_be          (dm_be),
    .dm_ack         (dm_ack),
    .dm_rdat        (dm_rdat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural result of one instruction.
  function automatic logic [31:0] ref_result(input op_t op, input logic [31:0] rdat);
    int unsigned b;
    if (op.mem) begin
      if (op.wr) return op.alu;
      if (!op.byt) return rdat;
      b = (rdat >> (8 * op.alu[1:0])) & 32'hFF;
      return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
    end
    if (op.mul) return 32'(op.alu * op.wdat);
    return op.alu;
  endfunction

  function automatic logic [3:0] ref_be(input op_t op);
    return op.byt ? 4'(1 << op.alu[1:0]) : 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdat(input op_t op);
    return op.byt ? 32'(op.wdat[7:0] * 32'h0101_0101) : op.wdat;
  endfunction

  task automatic drive(input op_t op);
    ALU_result_in   = op.alu;
    MEM_wdat_in     = op.wdat;
    w_in            = op.w;
    reg_wen_in      = op.reg_wen;
    data_mem_en_in  = op.mem;
    data_mem_wen_in = op.wr;
    mul_en_in       = op.mul;
    byte_en_in      = op.byt;
  endtask

  function automatic op_t mk(input logic [31:0] alu, input logic [31:0] wdat, input logic [4:0] w,
                             input logic reg_wen, input logic mem, input logic wr,
                             input logic mul, input logic byt);
    op_t o;
    o.alu = alu; o.wdat = wdat; o.w = w; o.reg_wen = reg_wen;
    o.mem = mem; o.wr = wr; o.mul = mul; o.byt = byt;
    return o;
  endfunction

  // One instruction from an idle stage: accept, run, present, optional
  // back-pressure of 'hold' cycles, then release back to idle.
  task automatic run_op(input op_t op, input int ack_delay, input logic [31:0] rdat, input int hold);
    logic [31:0] exp_res;
    exp_res = ref_result(op, rdat);
    @(negedge clk);
    drive(op);
    valid_in = 1'b1;
    allow_in = 1'b1;
    #1 check("accept_allow_out", 32'(allow_out), 32'd1);
    @(negedge clk);
    valid_in = 1'b0;
    drive(mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
    if (op.mem) begin
      for (int k = 1; k <= ack_delay; k++) begin
        check("mem_dm_req", 32'(dm_req), 32'd1);
        check("mem_dm_we", 32'(dm_we), 32'(op.wr));
        check("mem_dm_addr", dm_addr, op.alu & 32'hFFFF_FFFC);
        check("mem_dm_be", 32'(dm_be), 32'(ref_be(op)));
        check("mem_dm_wdat", dm_wdat, ref_wdat(op));
        check("mem_allow_out", 32'(allow_out), 32'd0);
        check("mem_valid_out", 32'(valid_out), 32'd0);
        if (k == ack_delay) begin
          dm_ack  = 1'b1;
          dm_rdat = rdat;
        end
        @(negedge clk);
        dm_ack  = 1'b0;
        dm_rdat = $urandom;
      end
    end else if (op.mul) begin
      for (int k = 1; k < int'(MUL_C); k++) begin
        check("mul_valid_out", 32'(valid_out), 32'd0);
        check("mul_dm_req", 32'(dm_req), 32'd0);
        check("mul_allow_out", 32'(allow_out), 32'd0);
        dm_ack = 1'($urandom);
        @(negedge clk);
      end
      dm_ack = 1'b0;
    end
    check("done_valid_out", 32'(valid_out), 32'd1);
    check("done_wb_dat", wb_dat_out, exp_res);
    check("done_w_out", 32'(w_out), 32'(op.w));
    check("done_reg_wen", 32'(reg_wen_out), 32'(op.reg_wen));
    check("done_dm_req", 32'(dm_req), 32'd0);
    for (int h = 0; h < hold; h++) begin
      allow_in = 1'b0;
      @(negedge clk);
      check("hold_valid_out", 32'(valid_out), 32'd1);
      check("hold_wb_dat", wb_dat_out, exp_res);
      check("hold_allow_out", 32'(allow_out), 32'd0);
    end
    allow_in = 1'b1;
    #1 check("release_allow_out", 32'(allow_out), 32'd1);
    @(negedge clk);
    check("idle_valid_out", 32'(valid_out), 32'd0);
    check("idle_reg_wen", 32'(reg_wen_out), 32'd0);
    check("idle_wb_kept", wb_dat_out, exp_res);
  endtask

  initial begin
    op_t o;
    int  r;

    // ---------------- reset ----------------
    rsta = 1'b1; valid_in = 1'b0; allow_in = 1'b0; dm_ack = 1'b0; dm_rdat = '0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("rst_allow_out", 32'(allow_out), 32'd1);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_wb_dat", wb_dat_out, 32'd0);
    check("rst_w_out", 32'(w_out), 32'd0);
    check("rst_reg_wen", 32'(reg_wen_out), 32'd0);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdat", dm_wdat, 32'd0);
    check("rst_dm_be", 32'(dm_be), 32'd0);
    rsta = 1'b0;
    allow_in = 1'b1;

    // ---------------- pass-through ----------------
    run_op(mk(32'h1234_5678, 0, 5, 1, 0, 0, 0, 0), 0, 0, 0);

    // Three back-to-back pass-through ops
    @(negedge clk);
    drive(mk(32'hA000_0001, 0, 1, 1, 0, 0, 0, 0)); valid_in = 1'b1;
    @(negedge clk);
    check("b2b0_valid", 32'(valid_out), 32'd1);
    check("b2b0_wb", wb_dat_out, 32'hA000_0001);
    drive(mk(32'hA000_0002, 0, 2, 1, 0, 0, 0, 0));
    @(negedge clk);
    check("b2b1_valid", 32'(valid_out), 32'd1);
    check("b2b1_wb", wb_dat_out, 32'hA000_0002);
    drive(mk(32'hA000_0003, 0, 3, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("b2b2_valid", 32'(valid_out), 32'd1);
    check("b2b2_wb", wb_dat_out, 32'hA000_0003);
    check("b2b2_reg_wen", 32'(reg_wen_out), 32'd0);
    valid_in = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'(valid_out), 32'd0);

    // ---------------- memory ----------------
    run_op(mk(32'h0000_1003, 32'h5555_AAAA, 8, 1, 1, 0, 0, 0), 3, 32'hDEAD_BEEF, 0);
    check("wordload_value", wb_dat_out, 32'hDEAD_BEEF);
    run_op(mk(32'h0000_2002, 0, 9, 1, 1, 0, 0, 1), 1, 32'h1180_3344, 0);
    check("lb_value", wb_dat_out, 32'hFFFF_FF80);
    run_op(mk(32'h0000_2001, 32'h0000_00AB, 0, 0, 1, 1, 0, 1), 2, 32'h0, 0);

    // ---------------- multiply ----------------
    run_op(mk(32'hFFFF_FFFF, 32'd3, 10, 1, 0, 0, 1, 0), 0, 0, 0);
    check("mul_value", wb_dat_out, 32'hFFFF_FFFD);

    // ---------------- back-pressure ----------------
    @(negedge clk);
    drive(mk(32'hCAFE_0001, 0, 7, 1, 0, 0, 0, 0)); valid_in = 1'b1; allow_in = 1'b1;
    @(negedge clk);
    check("bp_first_valid", 32'(valid_out), 32'd1);
    drive(mk(32'h0BAD_0002, 0, 9, 1, 0, 0, 0, 0)); allow_in = 1'b0;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      check("bp_valid", 32'(valid_out), 32'd1);
      check("bp_wb", wb_dat_out, 32'hCAFE_0001);
      check("bp_w_out", 32'(w_out), 32'd7);
      check("bp_allow_out", 32'(allow_out), 32'd0);
    end
    allow_in = 1'b1;
    #1 check("bp_release_allow", 32'(allow_out), 32'd1);
    @(negedge clk);
    check("bp_next_valid", 32'(valid_out), 32'd1);
    check("bp_next_wb", wb_dat_out, 32'h0BAD_0002);
    check("bp_next_w", 32'(w_out), 32'd9);
    valid_in = 1'b0;
    @(negedge clk);
    check("bp_idle", 32'(valid_out), 32'd0);

    // ---------------- reset mid-access ----------------
    drive(mk(32'h0000_3000, 0, 4, 1, 1, 0, 0, 0)); valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check("rstmid_req1", 32'(dm_req), 32'd1);
    @(negedge clk);
    check("rstmid_req2", 32'(dm_req), 32'd1);
    rsta = 1'b1;
    @(negedge clk);
    check("rstmid_dm_req", 32'(dm_req), 32'd0);
    check("rstmid_valid", 32'(valid_out), 32'd0);
    check("rstmid_allow", 32'(allow_out), 32'd1);
    check("rstmid_wb", wb_dat_out, 32'd0);
    rsta = 1'b0; dm_ack = 1'b1; dm_rdat = 32'h7777_7777;
    @(negedge clk);
    dm_ack = 1'b0;
    check("late_ack_valid", 32'(valid_out), 32'd0);
    check("late_ack_req", 32'(dm_req), 32'd0);
    @(negedge clk);
    check("late_ack_valid2", 32'(valid_out), 32'd0);
    check("late_ack_allow", 32'(allow_out), 32'd1);

    // ---------------- randomized ----------------
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      o = mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom));
      if (r < 4) o.mem = 1'b1;
      else if (r < 6) o.mul = 1'b1;
      else if (r == 6) begin o.mem = 1'b1; o.mul = 1'b1; end
      run_op(o, int'($urandom_range(1, 4)), $urandom, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB register. It takes the EX/MEM outputs, performs word or byte loads and stores on the data-memory bus with a request/acknowledge handshake, and runs a multi-cycle multiply when `mul_en` is set. It then presents one write-back result per instruction to MEM/WB, back-pressuring EX/MEM through `allow_out` while busy.

## Interface
- `MUL_CYCLES`, 2: cycles a multiply occupies the stage, counted from acceptance to result; legal range 1–15.
- `clk` in 1: clock, all state changes on rising edge.
- `rsta` in 1: reset. One clock; reset is synchronous and active-high.
- `valid_in` in 1: EX/MEM holds a valid instruction.
- `allow_out` out 1: stage accepts an instruction this cycle; fed back to EX/MEM.
- `ALU_result_in` in 32: memory address, or pass-through result, or multiplicand.
- `w_in` in 5: destination register.
- `data_mem_en_in` in 1: memory access.
- `data_mem_wen_in` in 1: access is a store (with `data_mem_en_in`).
- `reg_wen_in` in 1: register write-back enable.
- `MEM_wdat_in` in 32: store data, or multiplier.
- `mul_en_in` in 1: multiply instruction.
- `byte_en_in` in 1: byte-sized access (lb/sb) instead of word.
- `allow_in` in 1: MEM/WB accepts the presented result.
- `valid_out` out 1: result valid toward MEM/WB.
- `wb_dat_out` out 32: write-back data.
- `w_out` out 5: destination register.
- `reg_wen_out` out 1: register write enable.
- `dm_req` out 1: memory request.
- `dm_we` out 1: request is a write.
- `dm_addr` out 32: word-aligned address.
- `dm_wdat` out 32: write data.
- `dm_be` out 4: byte-lane enables.
- `dm_ack` in 1: memory completion; read data valid in the same cycle.
- `dm_rdat` in 32: read data.

## Operation
- States: IDLE, MEM, MUL, DONE. Reset (sync) → IDLE. All outputs and holding registers are 0, and `allow_out`=1.
- `allow_out` = (IDLE) or (DONE and `allow_in`). This is combinational.
- Accept: `valid_in` and `allow_out` at an edge capture all `*_in` fields. Next state:
  - MEM if `data_mem_en_in`. `data_mem_en_in` wins over `mul_en_in` when both are set.
  - MUL if `mul_en_in`; the counter loads `MUL_CYCLES`-1.
  - DONE otherwise; the result is `ALU_result_in`.
- MEM: `dm_req`=1 for every cycle in this state, with stable `dm_we`/`dm_addr`/`dm_wdat`/`dm_be`.
  - `dm_addr` = {addr[31:2],2'b00}.
  - Word access: `dm_be`=4'b1111, `dm_wdat`=store data.
  - Byte access: `dm_be`=1<<addr[1:0], `dm_wdat`={4{data[7:0]}}.
  - On `dm_ack`:
    - Load: result = word, or the byte from lane addr[1:0] sign-extended (little-endian).
    - Store: result = ALU_result.
    - Next state is DONE.
- `dm_ack` outside MEM is ignored. `dm_req`=0 outside MEM.
- MUL: the counter decrements each cycle. At 0, result = low 32 bits of ALU_result*MEM_wdat (unsigned/two's-complement low word is identical), and the next state is DONE. With `MUL_CYCLES`=1, acceptance goes straight to DONE with the product.
- DONE: `valid_out`=1 and `wb_dat_out`/`w_out`/`reg_wen_out` are held stable. On `allow_in`:
  - If `valid_in`, accept the next instruction (back-to-back).
  - Otherwise go to IDLE.
- `valid_out`=0 and `reg_wen_out`=0 outside DONE. `wb_dat_out`/`w_out` keep their last value.
- `rsta` mid-operation (any state, including MEM with `dm_req` high) returns to IDLE next edge. It drops `dm_req` and discards the in-flight instruction; a late `dm_ack` is ignored.

## Timing
- Pass-through op accepted at edge N: `valid_out`=1 in cycle N+1. Throughput is one instruction per cycle while `allow_in`=1.
- Memory op accepted at N: `dm_req` from N+1. If `dm_ack` arrives in cycle N+k (k≥1), `valid_out` is high from N+k+1. Minimum latency is 2 cycles.
- Multiply accepted at N: `valid_out` from N+`MUL_CYCLES`.
- `allow_out` is low in MEM and MUL, and in DONE while `allow_in`=0.
- No combinational path from `dm_rdat`/`dm_ack` to the output ports; `allow_in`→`allow_out` is the only comb path.

## Test plan
- Reset then pass-through:
  - Stimulus: assert `rsta` 2 cycles; check all outputs 0 and `allow_out`=1. Then send ALU_result=0x12345678, w=5, reg_wen=1, `allow_in`=1.
  - Required: `valid_out`=1 next cycle with `wb_dat_out`=0x12345678, `w_out`=5. Three back-to-back ops produce 3 consecutive valid cycles.
- Word load with wait states:
  - Stimulus: addr 0x1003, `dm_ack` after 3 cycles with `dm_rdat`=0xDEADBEEF.
  - Required: `dm_addr`=0x1000, `dm_be`=1111, `dm_req` high exactly 3 cycles, `allow_out`=0 throughout, `wb_dat_out`=0xDEADBEEF.
- Byte load/store lanes:
  - lb from addr 0x2002, `dm_rdat`=0x11803344 → `wb_dat_out`=0xFFFFFF80.
  - sb at 0x2001, data 0xAB → `dm_be`=0010, `dm_wdat`=0xABABABAB, `dm_we`=1.
- Multiply (`MUL_CYCLES`=2):
  - Stimulus: 0xFFFFFFFF * 3.
  - Required: `valid_out` 2 cycles after acceptance with 0xFFFFFFFD; `dm_req` stays 0.
- Back-pressure:
  - Stimulus: hold `allow_in`=0 for 4 cycles in DONE while `valid_in`=1.
  - Required: outputs stable and `allow_out`=0. Raising `allow_in` accepts the next instruction the same cycle.
- Reset mid-access:
  - Stimulus: `rsta` during MEM before `dm_ack`, then `dm_ack` pulsed after reset.
  - Required: `dm_req`=0 and state IDLE after the edge; no `valid_out`.
